// File: rtl/ped_request_conditioner_if.sv
// Button-side and controller-side signals of the pedestrian request conditioner.
// The conditioner takes the slave view; whoever drives the button and walk phase takes the master view.
interface ped_request_conditioner_if;
    logic        btn_raw;
    logic        ped_walk;
    logic        ped_req;
    logic        wait_lamp;
    logic [15:0] req_count;

    modport master (
        output btn_raw,
        output ped_walk,
        input  ped_req,
        input  wait_lamp,
        input  req_count
    );

    modport slave (
        input  btn_raw,
        input  ped_walk,
        output ped_req,
        output wait_lamp,
        output req_count
    );
endinterface

// File: rtl/ped_request_conditioner.sv
// Synchronises and debounces the pedestrian button, issues one request pulse per accepted press,
// re-pulses while unanswered, and holds off new requests through the walk phase plus a lockout.
module ped_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 16,
    parameter int REQ_TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ped_request_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, WALK, LOCKOUT} state_t;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = (LOCKOUT_CYCLES  > 1) ? $clog2(LOCKOUT_CYCLES)  : 1;
    localparam int TW = (REQ_TIMEOUT     > 1) ? $clog2(REQ_TIMEOUT)     : 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] T_LAST = TW'((REQ_TIMEOUT > 0) ? REQ_TIMEOUT - 1 : 0);

    logic [1:0]    sync;
    logic          s;
    logic          db;
    logic          db_q;
    logic [DW-1:0] dcnt;
    logic          press;

    state_t        state, state_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [LW-1:0] lcnt, lcnt_next;
    logic          req_next;
    logic [15:0]   count_next;

    assign s     = sync[1];
    assign press = db & ~db_q;

    // NOTE: every clocked process uses non-blocking assignments so all flops update
    // from pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            db   <= 1'b0;
            db_q <= 1'b0;
            dcnt <= '0;
        end else begin
            sync <= {sync[0], bus.btn_raw};
            db_q <= db;
            // Any bounce back to the current level restarts the count.
            if (s == db) begin
                dcnt <= '0;
            end else if (dcnt == D_LAST) begin
                db   <= s;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        lcnt_next  = lcnt;
        req_next   = 1'b0;
        count_next = bus.req_count;

        unique case (state)
            IDLE: begin
                // Walk beats a same-cycle press: the controller is already serving pedestrians.
                if (bus.ped_walk) begin
                    state_next = WALK;
                end else if (press) begin
                    state_next = WAIT;
                    req_next   = 1'b1;
                    tcnt_next  = '0;
                    if (bus.req_count != 16'hFFFF) count_next = bus.req_count + 16'd1;
                end
            end
            WAIT: begin
                if (bus.ped_walk) begin
                    state_next = WALK;
                end else if (REQ_TIMEOUT != 0) begin
                    if (tcnt == T_LAST) begin
                        req_next  = 1'b1;
                        tcnt_next = '0;
                    end else begin
                        tcnt_next = tcnt + 1'b1;
                    end
                end
            end
            WALK: begin
                if (!bus.ped_walk) begin
                    state_next = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
                    lcnt_next  = '0;
                end
            end
            LOCKOUT: begin
                if (bus.ped_walk) begin
                    state_next = WALK;
                end else if (lcnt == L_LAST) begin
                    state_next = IDLE;
                end else begin
                    lcnt_next = lcnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            lcnt          <= '0;
            bus.ped_req   <= 1'b0;
            bus.wait_lamp <= 1'b0;
            bus.req_count <= 16'd0;
        end else begin
            state         <= state_next;
            tcnt          <= tcnt_next;
            lcnt          <= lcnt_next;
            bus.ped_req   <= req_next;
            bus.wait_lamp <= (state_next == WAIT);
            bus.req_count <= count_next;
        end
    end

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: directed scenarios with literal expectations,
// then random button/walk traffic against a behavioural model compared every cycle.
module tb_ped_request_conditioner;

    localparam int D = 4;
    localparam int L = 16;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ped_request_conditioner_if bus ();

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L),
        .REQ_TIMEOUT    (T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;

    // Behavioural model: pipeline bits, run-length debounce, mode flags and countdowns.
    bit m_s1, m_s2, m_db, m_dbq;
    bit m_waiting, m_walking, m_req;
    int m_run, m_lock_left, m_since, m_count;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0;
        m_waiting = 0; m_walking = 0; m_req = 0;
        m_run = 0; m_lock_left = 0; m_since = 0; m_count = 0;
    endtask

    task automatic model_step(input bit b, input bit w);
        bit s_old, db_old, press;
        s_old  = m_s2;
        db_old = m_db;
        press  = m_db & ~m_dbq;
        m_s2   = m_s1;
        m_s1   = b;
        m_dbq  = db_old;
        if (s_old != db_old) begin
            m_run++;
            if (m_run == D) begin
                m_db  = s_old;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_req = 0;
        if (m_walking) begin
            if (!w) begin
                m_walking   = 0;
                m_lock_left = L;
            end
        end else if (m_lock_left > 0) begin
            if (w) begin
                m_walking   = 1;
                m_lock_left = 0;
            end else begin
                m_lock_left--;
            end
        end else if (m_waiting) begin
            if (w) begin
                m_waiting = 0;
                m_walking = 1;
            end else if (T != 0) begin
                m_since++;
                if (m_since == T) begin
                    m_req   = 1;
                    m_since = 0;
                end
            end
        end else begin
            if (w) begin
                m_walking = 1;
            end else if (press) begin
                m_waiting = 1;
                m_req     = 1;
                m_since   = 0;
                if (m_count < 16'hFFFF) m_count++;
            end
        end
    endtask

    // One clock: drive at negedge, advance the model at the edge, compare at the next negedge.
    task automatic step(input bit b, input bit w);
        bus.btn_raw  = b;
        bus.ped_walk = w;
        @(posedge clk);
        model_step(b, w);
        cyc++;
        @(negedge clk);
        check("model_ped_req",   {15'd0, bus.ped_req},   {15'd0, m_req});
        check("model_wait_lamp", {15'd0, bus.wait_lamp}, {15'd0, m_waiting});
        check("model_req_count", bus.req_count,          16'(m_count));
    endtask

    task automatic reset_pulse(input bit b);
        bus.btn_raw = b;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ped_req",   {15'd0, bus.ped_req},   16'd0);
        check("rst_wait_lamp", {15'd0, bus.wait_lamp}, 16'd0);
        check("rst_req_count", bus.req_count,          16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int last_pulse;
        int n_pulses;
        int btn_left, walk_left;
        bit b, w;

        bus.btn_raw  = 1'b0;
        bus.ped_walk = 1'b0;
        model_reset();
        @(negedge clk);
        reset_pulse(1'b0);
        repeat (5) step(0, 0);

        // Clean press: request between edges 7 and 8, lamp from edge 7.
        last_pulse = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1, 0);
            check("clean_req",  {15'd0, bus.ped_req},   16'(k == 7));
            check("clean_lamp", {15'd0, bus.wait_lamp}, 16'(k >= 7));
        end
        check("clean_count", bus.req_count, 16'd1);
        repeat (10) step(0, 0);

        // Walk handshake with presses during walk and during lockout.
        step(0, 1);
        check("walk_lamp_fall", {15'd0, bus.wait_lamp}, 16'd0);
        for (int i = 1; i < 8; i++) begin
            step(1, 1);
            check("walk_no_req", {15'd0, bus.ped_req}, 16'd0);
        end
        for (int j = 0; j <= 16; j++) begin
            step(j == 0 || j >= 7, 0);
            check("lockout_no_req", {15'd0, bus.ped_req}, 16'd0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            check("held_no_rereq", {15'd0, bus.ped_req}, 16'd0);
        end
        check("lockout_count", bus.req_count, 16'd1);
        repeat (10) step(0, 0);
        for (int k = 1; k <= 12; k++) begin
            step(1, 0);
            check("second_req", {15'd0, bus.ped_req}, 16'(k == 7));
            if (bus.ped_req) last_pulse = cyc;
        end
        check("second_count", bus.req_count, 16'd2);

        // Timeout re-pulses every T cycles while walk stays low.
        n_pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 0);
            check("timeout_lamp", {15'd0, bus.wait_lamp}, 16'd1);
            if (bus.ped_req) begin
                check("timeout_gap", 16'(cyc - last_pulse), 16'(T));
                last_pulse = cyc;
                n_pulses++;
            end
        end
        check("timeout_pulses", 16'(n_pulses), 16'd3);
        check("timeout_count", bus.req_count, 16'd2);
        repeat (3) step(0, 1);
        repeat (20) step(0, 0);

        // Priority: walk rises on the same edge the press would be accepted.
        for (int k = 1; k <= 12; k++) begin
            step(1, k >= 7 && k <= 10);
            check("prio_no_req",  {15'd0, bus.ped_req},   16'd0);
            check("prio_no_lamp", {15'd0, bus.wait_lamp}, 16'd0);
        end
        repeat (20) step(1, 0);
        check("prio_count", bus.req_count, 16'd2);
        repeat (10) step(0, 0);

        // Reset mid-WAIT with the button held through release.
        for (int k = 1; k <= 12; k++) step(1, 0);
        check("prewait_lamp", {15'd0, bus.wait_lamp}, 16'd1);
        @(negedge clk);
        reset_pulse(1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1, 0);
            check("post_rst_req", {15'd0, bus.ped_req}, 16'(k == 7));
        end
        check("post_rst_count", bus.req_count, 16'd1);

        // Random traffic: bouncy button, sporadic walk phases, occasional resets.
        btn_left = 0;
        walk_left = 0;
        b = 0;
        w = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0) begin
                b = ~b;
                btn_left = (b && $urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                            : $urandom_range(1, 8);
            end
            if (walk_left == 0) begin
                w = ~w;
                walk_left = w ? $urandom_range(1, 12) : $urandom_range(1, 150);
            end
            btn_left--;
            walk_left--;
            if (i % 1300 == 1299) begin
                @(negedge clk);
                reset_pulse(b);
            end
            step(b, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ped_request_conditioner.md
# ped_request_conditioner

Conditions the raw pedestrian push-button into the clean, single-cycle `ped_req` pulse consumed by the intersection light controller, and drives the "WAIT" lamp on the button housing. It sits directly upstream of the controller on the same clock: it synchronises and debounces the button, issues one request per accepted press, holds off further requests until the controller's walk phase has completed plus a lockout interval, and re-issues the request if the controller never answers.

## Interface
- `DEBOUNCE_CYCLES`, default 4: cycles the synchronised button must hold a new level before the debounced level follows; legal range ≥1.
- `LOCKOUT_CYCLES`, default 16: cycles after `ped_walk` falls during which presses are ignored; 0 means no lockout.
- `REQ_TIMEOUT`, default 64: cycles in WAIT without `ped_walk` before `ped_req` is re-pulsed; 0 disables re-pulsing.
- `clk` input, 1 bit: the single clock, shared with the light controller.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `btn_raw` input, 1 bit: raw button, active-high, asynchronous, bouncy.
- `ped_walk` input, 1 bit: walk indication from the light controller; already synchronous to `clk`.
- `ped_req` output, 1 bit: registered single-cycle request pulse to the controller.
- `wait_lamp` output, 1 bit: registered; high while a request is outstanding.
- `req_count` output, 16 bits: registered count of accepted presses, saturating at 16'hFFFF.

## Operation
- Synchroniser: 2 flops, `btn_raw` → `s`. No other logic touches `btn_raw`.
- Debouncer: level `db` plus a counter `dcnt`.
  - If `s == db`, `dcnt <= 0`.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`, then `db <= s` and `dcnt <= 0`; else `dcnt <= dcnt+1`.
  - Any bounce that returns `s` to `db` restarts the count.
- Press event: `press = db & ~db_q`, where `db_q` is `db` delayed one cycle. A button held across any interval yields exactly one press.
- FSM states: IDLE, WAIT, WALK, LOCKOUT. Reset state is IDLE.
  - IDLE: `ped_walk=1` → WALK with no pulse; `ped_walk` has priority over a same-cycle press. Else `press` → WAIT, with `ped_req<=1`, `req_count` incremented (saturating), and timeout counter cleared.
  - WAIT: `wait_lamp=1`. `ped_walk=1` → WALK. Else, if `REQ_TIMEOUT≠0` and the timeout counter reaches `REQ_TIMEOUT-1`, then `ped_req<=1` and the counter is cleared. Further presses are ignored and not counted.
  - WALK: waits for `ped_walk=0`. On that event go to LOCKOUT, or to IDLE if `LOCKOUT_CYCLES=0`. Presses are ignored.
  - LOCKOUT: counts `LOCKOUT_CYCLES` cycles, then → IDLE. Presses are ignored. `ped_walk=1` → WALK.
- The `press` signal is a pure edge, so a button still held when LOCKOUT ends does not re-request; a fresh debounced press is required.
- Outputs:
  - `wait_lamp` is registered, equal to `(next_state==WAIT)`.
  - `ped_req` is high for exactly one cycle per issue and is never high on consecutive cycles.

## Timing
- Reset values: `ped_req=0`, `wait_lamp=0`, `req_count=0`, `db=0`, synchroniser flops 0, all counters 0, state IDLE. Assertion of `rst_n` mid-operation aborts immediately with no pulse.
- Press latency, with edge 1 being the first edge sampling `btn_raw=1` and the signal stable:
  - `s=1` after edge 2.
  - `db=1` after edge `DEBOUNCE_CYCLES+2`.
  - `ped_req` and `wait_lamp` high after edge `DEBOUNCE_CYCLES+3`; `ped_req` low again after the next edge.
  - With the default D=4, `ped_req` is high between edges 7 and 8.
- Release latency: symmetric; it does not affect outputs.
- Response to `ped_walk`: `wait_lamp` falls on the first edge sampling `ped_walk=1`.
- Re-pulse timing: a re-pulse occurs `REQ_TIMEOUT` cycles after the previous pulse, if `ped_walk` is still 0.
- Lockout: IDLE is re-entered `LOCKOUT_CYCLES` edges after the edge that sampled `ped_walk=0`. A press completing debounce on the cycle IDLE is entered is accepted.
- If the button is held through reset release, `db` still rises after D+2 edges and is accepted as a press.

## Test plan
- Clean press, defaults: `btn_raw` 0→1 held for 20 cycles → `ped_req` one cycle high after edge 7, `wait_lamp` high from edge 7, `req_count=1`; no second pulse.
- Bounce: `btn_raw` toggles 1,0,1,1,0 then holds 1 → exactly one `ped_req`, issued D+3 edges after the final 0→1; glitches shorter than D cycles produce nothing.
- Walk handshake: after the request, raise `ped_walk` for 8 cycles → `wait_lamp` falls on the first edge; presses during walk and during 16 lockout cycles produce no pulse and leave `req_count` unchanged; a press after lockout gives `req_count=2`.
- Timeout: with REQ_TIMEOUT=64, press and never assert `ped_walk` → `ped_req` re-pulses every 64 cycles, `wait_lamp` stays high, `req_count` stays 1.
- Priority: press debounce completes on the same cycle `ped_walk` rises in IDLE → no `ped_req`, state goes to WALK, `req_count` unchanged.
- Reset mid-WAIT: pull `rst_n` low → `wait_lamp=0` and `ped_req=0` immediately; with the button held through release, a new pulse appears after edge D+3.
